// File: rtl/ln_pipe.sv
// Natural log of a signed Q.FRAC sample: leading-one normalisation to m in [1,2), then a Taylor series in u = m-1.
// Latency N_TERMS cycles, one sample per cycle; the whole pipeline freezes while a result waits at the output.
module ln_pipe #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 10,
    parameter int N_TERMS = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    // Stages S0..S(N_TERMS-2); the last Taylor term is folded into the output register.
    localparam int NS = N_TERMS - 1;

    localparam longint LN2_L = ((longint'(693147) << FRAC) + 500000) / 1000000;
    localparam logic signed [WIDTH-1:0] LN2 = LN2_L[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(2 ** FRAC);

    typedef logic [N_TERMS:0][WIDTH-1:0] rtab_t;

    // round(2^FRAC / k), evaluated once at elaboration.
    function automatic rtab_t recip_tab();
        rtab_t t;
        t = '0;
        for (int k = 1; k <= N_TERMS; k++) begin
            t[k] = WIDTH'((2 ** FRAC + k / 2) / k);
        end
        return t;
    endfunction

    localparam rtab_t RK = recip_tab();

    // Full-width signed product, arithmetic shift back to Q.FRAC.
    function automatic logic signed [WIDTH-1:0] mul_q(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
        prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod = prod >>> FRAC;
        return prod[WIDTH-1:0];
    endfunction

    logic                    stall;
    logic                    out_valid_q, out_err_q;
    logic [WIDTH-1:0]        out_data_q;

    logic                    vld_q [NS];
    logic                    err_q [NS];
    logic signed [WIDTH-1:0] u_q   [NS];
    logic signed [WIDTH-1:0] pow_q [NS];
    logic signed [WIDTH-1:0] acc_q [NS];
    logic signed [WIDTH-1:0] e_q   [NS];

    logic                    vld_d [NS];
    logic                    err_d [NS];
    logic signed [WIDTH-1:0] u_d   [NS];
    logic signed [WIDTH-1:0] pow_d [NS];
    logic signed [WIDTH-1:0] acc_d [NS];
    logic signed [WIDTH-1:0] e_d   [NS];

    int                      lead_p;
    logic [WIDTH-1:0]        m_c;
    logic signed [WIDTH-1:0] u_c;
    logic signed [WIDTH-1:0] term_c;
    logic signed [WIDTH-1:0] pow_l, term_l, acc_l;
    logic [WIDTH-1:0]        out_data_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // S0 front end; the sign bit is excluded so x<=0 only produces masked garbage.
    always_comb begin
        lead_p = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (in_data[i]) lead_p = i;
        end
        if (lead_p >= FRAC) m_c = in_data >> (lead_p - FRAC);
        else                m_c = in_data << (FRAC - lead_p);
        u_c = $signed(m_c) - ONE;
    end

    always_comb begin
        term_c   = '0;
        vld_d[0] = in_valid;
        err_d[0] = in_data[WIDTH-1] || (in_data == '0);
        u_d[0]   = u_c;
        pow_d[0] = u_c;
        acc_d[0] = u_c;
        e_d[0]   = WIDTH'(lead_p - FRAC);
        // Stage j applies Taylor term k = j+1; even terms subtract.
        for (int j = 1; j < NS; j++) begin
            vld_d[j] = vld_q[j-1];
            err_d[j] = err_q[j-1];
            u_d[j]   = u_q[j-1];
            e_d[j]   = e_q[j-1];
            pow_d[j] = mul_q(pow_q[j-1], u_q[j-1]);
            term_c   = mul_q(pow_d[j], RK[j+1]);
            acc_d[j] = ((j + 1) % 2 == 0) ? acc_q[j-1] - term_c : acc_q[j-1] + term_c;
        end
    end

    always_comb begin
        pow_l  = mul_q(pow_q[NS-1], u_q[NS-1]);
        term_l = mul_q(pow_l, RK[N_TERMS]);
        acc_l  = (N_TERMS % 2 == 0) ? acc_q[NS-1] - term_l : acc_q[NS-1] + term_l;
        out_data_d = err_q[NS-1] ? '0 : acc_l + e_q[NS-1] * LN2;
    end

    always_ff @(posedge CLK) begin
        for (int j = 0; j < NS; j++) begin
            if (RST) begin
                vld_q[j] <= 1'b0;
            end else if (!stall) begin
                vld_q[j] <= vld_d[j];
                err_q[j] <= err_d[j];
                u_q[j]   <= u_d[j];
                pow_q[j] <= pow_d[j];
                acc_q[j] <= acc_d[j];
                e_q[j]   <= e_d[j];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            out_valid_q <= vld_q[NS-1];
            out_err_q   <= err_q[NS-1];
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_ln_pipe.sv
// Directed bench for ln_pipe at default parameters: latency, hand-computed logs, errors, backpressure, reset.
module tb_ln_pipe;
    localparam int W = 32;
    localparam int F = 10;
    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid, in_ready, out_valid, out_ready, out_err;
    logic [W-1:0] in_data, out_data;

    int vecs    = 0;
    int miscmp  = 0;
    int q_x[$];
    int q_d[$];
    int q_e[$];

    ln_pipe dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Straight-line reference: ln(x) via leading one, truncated Taylor series and e*ln2.
    function automatic int ref_ln(input int x);
        longint m, u, pw, acc, t;
        int p;
        if (x <= 0) return 0;
        p = 0;
        for (int i = 0; i < 31; i++) if (x[i]) p = i;
        m = (p >= F) ? (longint'(x) >>> (p - F)) : (longint'(x) <<< (F - p));
        u = m - (longint'(1) << F);
        pw = u;
        acc = u;
        for (int k = 2; k <= N; k++) begin
            pw = (pw * u) >>> F;
            t = (pw * ((longint'(1 << F) + k / 2) / k)) >>> F;
            acc = (k % 2 == 0) ? acc - t : acc + t;
        end
        return int'(acc + longint'(p - F) * 710);
    endfunction

    task automatic one_shot(input string tag, input logic [31:0] x, input logic [31:0] ed, input logic ee);
        @(negedge CLK);
        in_valid = 1'b1;
        in_data = x;
        out_ready = 1'b1;
        #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        for (int k = 1; k <= N; k++) begin
            @(negedge CLK);
            if (k == 1) in_valid = 1'b0;
            chk($sformatf("%s.vld@%0d", tag, k), 32'(out_valid), 32'(k == N));
        end
        chk({tag, ".data"}, out_data, ed);
        chk({tag, ".err"}, 32'(out_err), 32'(ee));
    endtask

    // Drives q_x in order, scoreboards against q_d/q_e; rnd toggles out_ready each cycle.
    task automatic run_stream(input string tag, input bit rnd);
        int idx = 0;
        int got = 0;
        int cyc = 0;
        while (got < q_x.size() && cyc < 500) begin
            @(negedge CLK);
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = (idx < q_x.size());
            if (in_valid) in_data = q_x[idx];
            #1;
            if (rnd) chk({tag, ".in_ready"}, 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                chk($sformatf("%s.data[%0d]", tag, got), out_data, q_d[got]);
                chk($sformatf("%s.err[%0d]", tag, got), 32'(out_err), q_e[got]);
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        chk({tag, ".count"}, got, q_x.size());
        if (!rnd) chk({tag, ".cycles"}, cyc, q_x.size() + N);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (N + 1) @(negedge CLK);
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
        q_x.delete();
        q_d.delete();
        q_e.delete();
    endtask

    initial begin
        int stale;
        int x;
        RST = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_err", 32'(out_err), 32'd0);
        chk("rst.out_data", out_data, 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        RST = 1'b0;

        one_shot("one", 32'd1024, 32'd0, 1'b0);

        q_x = '{2048, 512, 1536};
        q_d = '{710, -710, 410};
        q_e = '{0, 0, 0};
        run_stream("b2b", 1'b0);

        q_x = '{0, -1024, 2048};
        q_d = '{0, 0, 710};
        q_e = '{1, 1, 0};
        run_stream("err", 1'b0);

        for (int i = 0; i < W - 1; i++) begin
            q_x.push_back(1 << i);
            q_d.push_back((i - F) * 710);
            q_e.push_back(0);
        end
        run_stream("sweep", 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (i % 6 == 5) x = -int'($urandom_range(0, 3000));
            else            x = int'($urandom_range(1, 1 << 22));
            q_x.push_back(x);
            q_d.push_back(ref_ln(x));
            q_e.push_back(int'(x <= 0));
        end
        run_stream("rand", 1'b1);

        // Reset while three results are in flight and the head is stalled.
        @(negedge CLK);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'd2048;
        @(negedge CLK);
        in_data = 32'd512;
        @(negedge CLK);
        in_data = 32'd1536;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst2.stalled_valid", 32'(out_valid), 32'd1);
        chk("rst2.stalled_in_ready", 32'(in_ready), 32'd0);
        RST = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd2048;
        @(negedge CLK);
        chk("rst2.out_valid", 32'(out_valid), 32'd0);
        chk("rst2.out_data", out_data, 32'd0);
        chk("rst2.out_err", 32'(out_err), 32'd0);
        chk("rst2.in_ready", 32'(in_ready), 32'd1);
        RST = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge CLK);
            if (out_valid) stale++;
        end
        chk("rst2.stale", stale, 32'd0);
        one_shot("rst2.fresh", 32'd1536, 32'd410, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
